// File: rtl/mac_seq_fixp.sv
`timescale 1ns/1ps
// mac_seq_fixp
// Streaming fixed-point multiply-accumulate engine. One (weight, input)
// element pair is taken per cycle, products are summed in a guard-bit
// accumulator, and at end of vector the sum is rounded or truncated,
// saturated or wrapped, optionally ReLU-clamped, and presented as a
// single sBITW.FRACW result.
//
// Handshake rule (both sides): a transfer happens on the rising clock edge
// where valid and ready are both high. A producer holding valid with ready
// low must keep its data stable; the engine holds out_data/out_ovf stable
// while out_valid is high and out_ready is low.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   element handshake
//   in_w, in_x          weight and input, sBITW.FRACW
//   in_last             marks the final element of the vector
//   cfg_round           1 = round half up, 0 = truncate (floor)
//   cfg_sat             1 = saturate, 0 = wrap
//   cfg_relu            1 = clamp negative results to 0
//   out_valid/out_ready result handshake
//   out_data            result, sBITW.FRACW
//   out_ovf             result exceeded the BITW range (either mode)
//   state_dbg           current FSM state (ACC=0, FLUSH=1, CALC=2, DONE=3)
module mac_seq_fixp #(
    parameter int BITW  = 16,
    parameter int FRACW = 8,
    parameter int DIM   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITW-1:0] in_w,
    input  logic [BITW-1:0] in_x,
    input  logic            in_last,
    input  logic            cfg_round,
    input  logic            cfg_sat,
    input  logic            cfg_relu,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITW-1:0] out_data,
    output logic            out_ovf,
    output logic [1:0]      state_dbg
);

    localparam int ACCW = 2*BITW + $clog2(DIM) + 1;
    localparam int PRODW = 2*BITW;
    localparam int CNTW = $clog2(DIM+1);

    localparam logic signed [ACCW-1:0] ONE   = 1;
    localparam logic signed [ACCW-1:0] ZERO  = 0;
    localparam logic signed [ACCW-1:0] RND   = ONE <<< (FRACW-1);
    localparam logic signed [ACCW-1:0] MAX_R = (ONE <<< (BITW-1)) - ONE;
    localparam logic signed [ACCW-1:0] MIN_R = -(ONE <<< (BITW-1));
    localparam logic [BITW-1:0] MAX_OUT = {1'b0, {(BITW-1){1'b1}}};
    localparam logic [BITW-1:0] MIN_OUT = {1'b1, {(BITW-1){1'b0}}};

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        FLUSH = 2'd1,
        CALC  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state;
    logic signed [ACCW-1:0]  acc;
    logic signed [PRODW-1:0] prod;
    logic                    prod_v;
    logic [CNTW-1:0]         count;
    logic                    lat_round;
    logic                    lat_sat;
    logic                    lat_relu;

    logic signed [PRODW-1:0] prod_c;
    logic signed [ACCW-1:0]  prod_ext;
    logic signed [ACCW-1:0]  rnd_sum;
    logic signed [ACCW-1:0]  r_sh;
    logic                    ovf_c;
    logic [BITW-1:0]         res_c;
    logic                    is_last;

    assign in_ready  = (state == ACC);
    assign state_dbg = state;

    assign prod_c   = $signed(in_w) * $signed(in_x);
    assign prod_ext = {{(ACCW-PRODW){prod[PRODW-1]}}, prod};

    // The DIM-th element closes the vector whatever in_last says.
    assign is_last = in_last || (count == CNTW'(DIM-1));

    // Result path, evaluated from the settled accumulator during CALC.
    always_comb begin
        rnd_sum = acc + (lat_round ? RND : ZERO);
        r_sh    = rnd_sum >>> FRACW;
        ovf_c   = (r_sh > MAX_R) || (r_sh < MIN_R);
        res_c   = r_sh[BITW-1:0];
        if (lat_sat) begin
            if (r_sh > MAX_R) begin
                res_c = MAX_OUT;
            end else if (r_sh < MIN_R) begin
                res_c = MIN_OUT;
            end
        end
        // ReLU looks at the final (saturated or wrapped) value.
        if (lat_relu && res_c[BITW-1]) begin
            res_c = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACC;
            acc       <= '0;
            prod      <= '0;
            prod_v    <= 1'b0;
            count     <= '0;
            lat_round <= 1'b0;
            lat_sat   <= 1'b0;
            lat_relu  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    // Product pipeline: the product registered last cycle
                    // lands in the accumulator this cycle.
                    if (prod_v) begin
                        acc <= acc + prod_ext;
                    end
                    if (in_valid) begin
                        prod   <= prod_c;
                        prod_v <= 1'b1;
                        count  <= count + CNTW'(1);
                        if (count == '0) begin
                            lat_round <= cfg_round;
                            lat_sat   <= cfg_sat;
                            lat_relu  <= cfg_relu;
                        end
                        if (is_last) begin
                            state <= FLUSH;
                        end
                    end else begin
                        prod_v <= 1'b0;
                    end
                end
                FLUSH: begin
                    acc    <= acc + prod_ext;
                    prod_v <= 1'b0;
                    state  <= CALC;
                end
                CALC: begin
                    out_data  <= res_c;
                    out_ovf   <= ovf_c;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    count     <= '0;
                    prod_v    <= 1'b0;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ACC;
                    end
                end
                default: begin
                    state <= ACC;
                end
            endcase
        end
    end

endmodule

// File: doc/mac_seq_fixp.md
# mac_seq_fixp

Sequential fixed-point multiply-accumulate engine: the clocked, streaming successor to the combinational signed dot-product block. It accepts one (weight, input) element pair per cycle over a valid/ready handshake and accumulates a vector of up to DIM elements in a guard-bit accumulator. At end of vector it rounds or truncates, saturates or wraps, and applies an optional ReLU, producing one sBITW.FRACW result through an output valid/ready handshake. It sits between the weight/activation streamers and the neuron output buffer.

## Interface
- BITW, 16, operand and result width, two's complement
- FRACW, 8, fractional bits of operands and result
- DIM, 2, maximum vector length (≥1); accumulator width ACCW = 2*BITW + $clog2(DIM) + 1
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  element pair present
- in_ready  out  1  engine accepts an element this cycle
- in_w  in  BITW  weight, sBITW.FRACW
- in_x  in  BITW  input, sBITW.FRACW
- in_last  in  1  qualifies the final element of the vector
- cfg_round  in  1  1 = round half up, 0 = truncate (floor)
- cfg_sat  in  1  1 = saturate, 0 = wrap
- cfg_relu  in  1  1 = clamp negative results to 0
- out_valid  out  1  result held
- out_ready  in  1  consumer takes result
- out_data  out  BITW  result, sBITW.FRACW
- out_ovf  out  1  result exceeded the BITW range, in either mode

## Operation
- States: ACC, FLUSH, CALC, DONE. Reset state is ACC.
- ACC
  - in_ready=1. An element is accepted when in_valid && in_ready.
  - On acceptance: the signed full product in_w*in_x (2*BITW bits, 2*FRACW frac) is registered into prod with prod_v=1. Element count increments.
  - Each cycle with prod_v=1: acc += sign-extended prod.
- Last element: the accepted element with in_last=1, or the DIM-th accepted element (in_last ignored there). Accepting the last element moves the engine to FLUSH. count reaches at most DIM.
- cfg_round, cfg_sat and cfg_relu are latched when the first element of a vector is accepted and used for that vector's result.
- FLUSH: in_ready=0. The final product is added into acc. Next state is CALC.
- CALC
  - r = acc, plus 2^(FRACW-1) if round; then arithmetic shift right by FRACW.
  - Saturate mode: clamp r to [-2^(BITW-1), 2^(BITW-1)-1].
  - Wrap mode: take r[BITW-1:0].
  - out_ovf=1 if r lies outside that range, in either mode.
  - ReLU: a negative final value becomes 0. out_ovf is unaffected.
  - Load out_data and out_ovf, set out_valid=1, clear acc, count and prod_v. Next state is DONE.
- DONE: in_ready=0. Hold out_data, out_ovf and out_valid stable until out_ready. On handshake edge, clear out_valid and go to ACC.
- Accumulator never overflows internally (guard bits sized for DIM full-scale products).

## Timing
- Reset values: out_valid=0, out_data=0, out_ovf=0, acc=0, count=0, prod_v=0. in_ready=1 because the state is ACC. Nothing is accepted while rst_n=0.
- rst_n assertion mid-vector or mid-DONE discards all state immediately. No partial result is emitted.
- Throughput: 1 element/cycle in ACC, with no bubbles and in_valid gaps allowed.
- Latency: last element accepted at edge k → out_valid=1 after edge k+2. Minimum vector period is N+3 cycles with out_ready held at 1.
- out_ready=1 on the first DONE cycle → out_valid low and in_ready high after the next edge.
- in_valid while in_ready=0: the element is not consumed and the producer must hold it.
- Vector of length 1 (in_last on the first element) is legal: same latency.

## Test plan
- Truncate, sat, DIM=2: w=[2.0, 1.25], x=[5.0, 4.0] → out_data=0x0F00 (15.0), ovf=0, out_valid 2 cycles after last accept.
- Truncate vs round: w=[-1.15625, 0.359375], x=[2.25, -0.375] → truncate 0xFD43; same vector with cfg_round=1 → 0xFD44.
- Overflow: w=[100.0], x=[100.0], in_last=1.
  - sat → 0x7FFF, ovf=1.
  - wrap → 0x1000, ovf=1.
  - w=-100.0 with sat → 0x8000, ovf=1.
- ReLU and DIM cap (DIM=4): 5 elements of (1.0, -1.0) with no in_last → vector closes after 4, result 0x0000 with relu=1 and 0xFC00 with relu=0. The 5th element starts the next vector.
- Backpressure: hold out_ready=0 for 10 cycles. out_data stable, in_ready=0 throughout, in_valid elements not consumed. Release → the next vector's result is correct.
- Reset mid-vector: assert rst_n low after 1 of 2 elements. All outputs return to reset values; a following clean vector yields only its own result.
